// File: rtl/csr_tohost_reporter.sv
// Captures the tohost pass/fail write and reports it as a 10-byte UART frame:
// sync, status, test id, cycle count.
module csr_tohost_reporter #(
   parameter logic [11:0] TOHOST_ADDR = 12'h51E,
   parameter bit          REPORT_EN   = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        csr_we,
   input  logic [11:0] csr_addr,
   input  logic [31:0] csr_wdata,
   output logic [31:0] tohost,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        busy,
   output logic        done
);

   typedef enum logic [1:0] {IDLE, SEND, DONE} state_e;

   state_e      state_q;
   logic [31:0] tohost_q;
   logic [31:0] cnt_q;
   logic [31:0] cap_q;
   logic [3:0]  idx_q;
   logic [7:0]  txd_q;
   logic        txv_q;
   logic        busy_q;
   logic        done_q;

   logic        tohost_wr;
   logic        capture;
   logic [3:0]  idx_d;
   logic [7:0]  byte_d;

   function automatic logic [7:0] frame_byte(
      input logic [3:0]  i,
      input logic [31:0] th,
      input logic [31:0] cyc
   );
      logic [31:0] id;
      logic [7:0]  b;
      id = {1'b0, th[31:1]};
      case (i)
         4'd0:    b = 8'hA5;
         4'd1:    b = (th[31:1] == 31'd0) ? 8'h50 : 8'h46;
         4'd2:    b = id[7:0];
         4'd3:    b = id[15:8];
         4'd4:    b = id[23:16];
         4'd5:    b = id[31:24];
         4'd6:    b = cyc[7:0];
         4'd7:    b = cyc[15:8];
         4'd8:    b = cyc[23:16];
         4'd9:    b = cyc[31:24];
         default: b = 8'h00;
      endcase
      return b;
   endfunction

   // Writes are only accepted while idle so the reported frame never changes
   assign tohost_wr = csr_we && (csr_addr == TOHOST_ADDR) && (state_q == IDLE);
   assign capture   = tohost_wr && csr_wdata[0];
   assign idx_d     = idx_q + 4'd1;
   assign byte_d    = frame_byte(idx_d, tohost_q, cap_q);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         tohost_q <= '0;
         cnt_q    <= '0;
         cap_q    <= '0;
         idx_q    <= '0;
         txd_q    <= '0;
         txv_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         if (tohost_wr) tohost_q <= csr_wdata;
         unique case (state_q)
            IDLE: begin
               if (capture) begin
                  cap_q <= cnt_q;
                  idx_q <= '0;
                  if (REPORT_EN) begin
                     state_q <= SEND;
                     txv_q   <= 1'b1;
                     txd_q   <= 8'hA5;
                     busy_q  <= 1'b1;
                  end else begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                  end
               end else if (cnt_q != '1) begin
                  cnt_q <= cnt_q + 32'd1;
               end
            end
            SEND: begin
               if (tx_ready) begin
                  if (idx_q == 4'd9) begin
                     state_q <= DONE;
                     txv_q   <= 1'b0;
                     txd_q   <= '0;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end else begin
                     idx_q <= idx_d;
                     txd_q <= byte_d;
                  end
               end
            end
            DONE: ;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign tohost   = tohost_q;
   assign tx_data  = txd_q;
   assign tx_valid = txv_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule

// File: tb/tb_csr_tohost_reporter.sv
// Directed bench for csr_tohost_reporter, reporting and non-reporting
// instances driven side by side.
module tb_csr_tohost_reporter;

   logic        clk;
   logic        rst;
   logic        csr_we;
   logic [11:0] csr_addr;
   logic [31:0] csr_wdata;
   logic        tx_ready;

   logic [31:0] tohost;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        busy;
   logic        done;

   logic [31:0] n_tohost;
   logic [7:0]  n_tx_data;
   logic        n_tx_valid;
   logic        n_busy;
   logic        n_done;

   int n_chk = 0;
   int n_err = 0;

   csr_tohost_reporter #(.TOHOST_ADDR(12'h51E), .REPORT_EN(1'b1)) u_dut (
      .clk(clk), .rst(rst),
      .csr_we(csr_we), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
      .tohost(tohost), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .busy(busy), .done(done)
   );

   csr_tohost_reporter #(.TOHOST_ADDR(12'h51E), .REPORT_EN(1'b0)) u_dut_nr (
      .clk(clk), .rst(rst),
      .csr_we(csr_we), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
      .tohost(n_tohost), .tx_data(n_tx_data), .tx_valid(n_tx_valid),
      .tx_ready(tx_ready), .busy(n_busy), .done(n_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst       = 1'b0;
      csr_we    = 1'b0;
      csr_addr  = '0;
      csr_wdata = '0;
      tx_ready  = 1'b0;
      #1;
      chk("rst_tohost", tohost, 32'h0);
      chk("rst_txv", {31'd0, tx_valid}, 32'h0);
      chk("rst_txd", {24'd0, tx_data}, 32'h0);
      chk("rst_busy", {31'd0, busy}, 32'h0);
      chk("rst_done", {31'd0, done}, 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   // Called at a negedge; the write lands on the following posedge
   task automatic wr(input logic [11:0] a, input logic [31:0] d);
      csr_we    = 1'b1;
      csr_addr  = a;
      csr_wdata = d;
      @(negedge clk);
      csr_we    = 1'b0;
   endtask

   task automatic run_frame(input string tag, input logic [7:0] exp [10],
                            input bit bp, output int cyc);
      int   k;
      int   t;
      bit   hold;
      logic [7:0] held;
      logic [3:0] pat;
      k    = 0;
      t    = 0;
      hold = 1'b0;
      held = '0;
      pat  = 4'b1001;
      while (k < 10 && t < 200) begin
         chk({tag, "_txv"}, {31'd0, tx_valid}, 32'h1);
         chk({tag, "_busy"}, {31'd0, busy}, 32'h1);
         if (hold) chk({tag, "_hold"}, {24'd0, tx_data}, {24'd0, held});
         tx_ready = bp ? pat[3 - (t % 4)] : 1'b1;
         if (tx_ready) begin
            chk({tag, "_byte"}, {24'd0, tx_data}, {24'd0, exp[k]});
            k++;
            hold = 1'b0;
         end else begin
            hold = 1'b1;
            held = tx_data;
         end
         @(negedge clk);
         t++;
      end
      if (k < 10) chk({tag, "_timeout"}, k, 10);
      tx_ready = 1'b0;
      cyc = t;
      chk({tag, "_done"}, {31'd0, done}, 32'h1);
      chk({tag, "_busy_end"}, {31'd0, busy}, 32'h0);
      chk({tag, "_txv_end"}, {31'd0, tx_valid}, 32'h0);
   endtask

   logic [7:0] f_pass [10];
   logic [7:0] f_fail [10];
   logic [7:0] f_filt [10];
   int         cyc;

   initial begin
      f_pass = '{8'hA5, 8'h50, 8'h00, 8'h00, 8'h00, 8'h00,
                 8'h05, 8'h00, 8'h00, 8'h00};
      f_fail = '{8'hA5, 8'h46, 8'h03, 8'h00, 8'h00, 8'h00,
                 8'h05, 8'h00, 8'h00, 8'h00};
      f_filt = '{8'hA5, 8'h50, 8'h00, 8'h00, 8'h00, 8'h00,
                 8'h07, 8'h00, 8'h00, 8'h00};

      // Pass frame, tx_ready held high
      do_reset();
      repeat (5) @(negedge clk);
      chk("pass_idle_txv", {31'd0, tx_valid}, 32'h0);
      wr(12'h51E, 32'h1);
      chk("pass_first", {24'd0, tx_data}, 32'hA5);
      run_frame("pass", f_pass, 1'b0, cyc);
      chk("pass_latency", cyc, 10);
      chk("pass_tohost", tohost, 32'h1);
      wr(12'h51E, 32'h3);
      chk("done_freeze", tohost, 32'h1);
      chk("done_stays", {31'd0, done}, 32'h1);

      // Fail frame
      do_reset();
      repeat (5) @(negedge clk);
      wr(12'h51E, 32'h7);
      chk("fail_tohost", tohost, 32'h7);
      run_frame("fail", f_fail, 1'b0, cyc);

      // Backpressure 1-0-0-1
      do_reset();
      repeat (5) @(negedge clk);
      wr(12'h51E, 32'h1);
      run_frame("bp", f_pass, 1'b1, cyc);

      // Address filtering and non-terminating write
      do_reset();
      repeat (5) @(negedge clk);
      wr(12'h51F, 32'h1);
      chk("filt_addr_tohost", tohost, 32'h0);
      chk("filt_addr_txv", {31'd0, tx_valid}, 32'h0);
      wr(12'h51E, 32'h4);
      chk("filt_even_tohost", tohost, 32'h4);
      chk("filt_even_txv", {31'd0, tx_valid}, 32'h0);
      chk("filt_even_busy", {31'd0, busy}, 32'h0);
      wr(12'h51E, 32'h1);
      run_frame("filt", f_filt, 1'b0, cyc);

      // Freeze during SEND, then reset mid-frame
      do_reset();
      repeat (5) @(negedge clk);
      wr(12'h51E, 32'h1);
      wr(12'h51E, 32'h9);
      chk("frz_tohost", tohost, 32'h1);
      chk("frz_byte0", {24'd0, tx_data}, 32'hA5);
      tx_ready = 1'b1;
      repeat (3) @(negedge clk);
      tx_ready = 1'b0;
      chk("frz_byte3", {24'd0, tx_data}, 32'h00);
      chk("frz_busy", {31'd0, busy}, 32'h1);
      #2 rst = 1'b0;
      #1;
      chk("abort_txv", {31'd0, tx_valid}, 32'h0);
      chk("abort_txd", {24'd0, tx_data}, 32'h0);
      chk("abort_busy", {31'd0, busy}, 32'h0);
      chk("abort_done", {31'd0, done}, 32'h0);
      chk("abort_tohost", tohost, 32'h0);
      @(negedge clk);
      rst = 1'b1;
      repeat (5) @(negedge clk);
      wr(12'h51E, 32'h1);
      run_frame("fresh", f_pass, 1'b0, cyc);

      // Non-reporting instance
      do_reset();
      repeat (5) @(negedge clk);
      chk("nr_pre_done", {31'd0, n_done}, 32'h0);
      wr(12'h51E, 32'h1);
      chk("nr_done", {31'd0, n_done}, 32'h1);
      chk("nr_busy", {31'd0, n_busy}, 32'h0);
      chk("nr_tohost", n_tohost, 32'h1);
      tx_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("nr_txv", {31'd0, n_tx_valid}, 32'h0);
         @(negedge clk);
      end
      tx_ready = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/csr_tohost_reporter.md
CSR_TOHOST_REPORTER -- requirements
Module: csr_tohost_reporter

Interface
REQ-001 SHALL have parameter TOHOST_ADDR, default 12'h51E, the CSR address of the tohost register.
REQ-002 SHALL have parameter REPORT_EN, default 1; 1 sends a result frame, 0 suppresses it.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset (asserted when 0).
REQ-005 SHALL have port csr_we  input  1  CSR write strobe from the pipeline writeback stage.
REQ-006 SHALL have port csr_addr  input  12  CSR write address.
REQ-007 SHALL have port csr_wdata  input  32  CSR write data.
REQ-008 SHALL have port tohost  output  32  current tohost register value.
REQ-009 SHALL have port tx_data  output  8  frame byte to the UART transmitter.
REQ-010 SHALL have port tx_valid  output  1  tx_data holds a valid byte.
REQ-011 SHALL have port tx_ready  input  1  UART transmitter accepts the byte this cycle.
REQ-012 SHALL have port busy  output  1  frame transmission in progress.
REQ-013 SHALL have port done  output  1  test result captured and, if enabled, fully reported.

Function
REQ-014 SHALL count cycles in a 32-bit counter: 0 on reset, +1 per cycle, saturating at 32'hFFFF_FFFF, frozen once a result is captured.
REQ-015 SHALL write tohost with csr_wdata on a clock edge where csr_we=1, csr_addr=TOHOST_ADDR and state is IDLE; any other address is ignored.
REQ-016 SHALL implement states IDLE, SEND, DONE.
REQ-017 IDLE: a tohost write with csr_wdata[0]=1 SHALL capture the cycle counter value of that cycle and move to SEND (REPORT_EN=1) or DONE (REPORT_EN=0) on the same edge.
REQ-018 IDLE: a tohost write with csr_wdata[0]=0 SHALL update tohost only and remain in IDLE.
REQ-019 SEND SHALL emit exactly 10 bytes in order: 8'hA5; status 8'h50 ('P') if csr_wdata[31:1]==0, else 8'h46 ('F'); {1'b0,tohost[31:1]} as 4 bytes LSB first; captured cycle count as 4 bytes LSB first.
REQ-020 tx_valid SHALL be 1 in every SEND cycle; tx_data SHALL stay stable until the cycle with tx_valid=1 and tx_ready=1 (handshake).
REQ-021 A handshake SHALL advance a 4-bit byte index on that edge; the handshake on byte index 9 SHALL move to DONE.
REQ-022 tx_ready while not in SEND SHALL have no effect.
REQ-023 busy SHALL equal (state==SEND); done SHALL equal (state==DONE); both are registered state decodes.
REQ-024 In SEND and DONE, tohost writes SHALL be ignored, so tohost and frame contents stay frozen; DONE SHALL be exited only by reset.
REQ-025 With tx_ready held 1, first byte SHALL appear the cycle after capture and done SHALL rise 10 cycles after entering SEND.
REQ-026 With REPORT_EN=0, tx_valid SHALL stay 0 and done SHALL rise the cycle after capture.

Reset
REQ-027 rst=0 SHALL immediately force state IDLE, tohost=0, cycle counter=0, byte index=0, tx_valid=0, tx_data=0, busy=0, done=0.
REQ-028 Reset asserted mid-frame SHALL abort the frame with no further byte handshakes; after release the block SHALL behave as fresh from reset.
REQ-029 The first rising edge after rst returns to 1 SHALL be a normal operating edge (counter becomes 1).

Verification
REQ-030 Pass: 5 idle cycles after reset, write TOHOST_ADDR=32'h1, tx_ready=1 -> bytes A5 50 00 00 00 00 05 00 00 00, then done=1, tohost=32'h1.
REQ-031 Fail: write 32'h0000_0007 -> status byte 46, id bytes 03 00 00 00, tohost=32'h7.
REQ-032 Backpressure: tx_ready toggled 1-0-0-1 repeatedly -> identical 10-byte sequence, tx_data constant while tx_ready=0, busy=1 until final handshake.
REQ-033 Filtering: writes to 12'h51F, and a tohost write of 32'h4 -> tohost=32'h4 after the second only, no tx_valid; a later write of 32'h1 reports status 50.
REQ-034 Freeze/reset: write 32'h1, then write 32'h9 during SEND -> tohost stays 32'h1; drop rst at byte 3 -> tx_valid=0 immediately, all outputs 0.
REQ-035 REPORT_EN=0: write 32'h1 -> tx_valid never 1, done=1 one cycle later.
